// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: width math and a width-generic saturator.
package adder_tree_pkg;

  localparam int unsigned SAT_W  = 64;
  localparam int unsigned SAT_TW = SAT_W + 1;
  localparam int unsigned SAT_IW = 7;

  typedef struct packed {
    logic             clamp;
    logic [SAT_W-1:0] value;
  } sat_res_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Output width of tree level lvl (level 0 is the raw lane width)
  function automatic int unsigned level_w(input int unsigned in_w, input int unsigned lvl);
    return in_w + lvl;
  endfunction

  function automatic int unsigned tree_w(input int unsigned in_w, input int unsigned num_in);
    return level_w(in_w, clog2(num_in));
  endfunction

  // t holds an exact (w+1)-bit sum in its low bits; clamp it to w bits
  function automatic sat_res_t saturate(input logic [SAT_TW-1:0] t, input int unsigned w,
                                        input bit is_signed);
    sat_res_t         r;
    logic [SAT_W-1:0] all_ones;
    logic [SAT_W-1:0] max_pos;
    logic [SAT_W-1:0] min_neg;
    logic [SAT_IW-1:0] msb;
    all_ones = {SAT_W{1'b1}} >> (SAT_W - w);
    max_pos  = all_ones >> 1;
    min_neg  = all_ones & ~max_pos;
    msb      = SAT_IW'(w);
    r.clamp  = 1'b0;
    r.value  = t[SAT_W-1:0] & all_ones;
    if (!is_signed) begin
      if (t[msb]) begin
        r.clamp = 1'b1;
        r.value = all_ones;
      end
    end else if (t[msb] != t[msb - SAT_IW'(1)]) begin
      r.clamp = 1'b1;
      r.value = t[msb] ? min_neg : max_pos;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_acc_level.sv
// One registered level of the adder tree: adds adjacent operand pairs, one bit wider.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_PAIRS = 4,
  parameter int unsigned W_IN    = 8,
  parameter int unsigned SIGNED  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic                           in_ci,
  input  logic [2*N_PAIRS*W_IN-1:0]      in_ops,
  output logic [N_PAIRS*(W_IN+1)-1:0]    out_sums,
  output logic                           out_valid,
  output logic                           out_last
);

  localparam int unsigned W_OUT = level_w(W_IN, 1);
  localparam logic        SX    = (SIGNED != 0);

  logic [N_PAIRS*W_OUT-1:0] sums_c;
  logic [W_IN-1:0]          a;
  logic [W_IN-1:0]          b;

  // Carry-in rides on pair 0 only; the extra bit absorbs it without overflow
  always_comb begin
    sums_c = '0;
    a      = '0;
    b      = '0;
    for (int p = 0; p < int'(N_PAIRS); p++) begin
      a = in_ops[2*p*W_IN +: W_IN];
      b = in_ops[(2*p+1)*W_IN +: W_IN];
      sums_c[p*W_OUT +: W_OUT] = {SX & a[W_IN-1], a} + {SX & b[W_IN-1], b}
                                 + W_OUT'(p == 0 ? in_ci : 1'b0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sums  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_sums  <= sums_c;
      out_valid <= in_valid;
      out_last  <= in_valid & in_last;
    end
  end

endmodule

// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined multi-operand adder tree feeding a saturating per-packet accumulator.
module pipelined_adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic                     in_ci,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_ovf
);

  localparam int unsigned L      = clog2(NUM_IN);
  localparam int unsigned TREE_W = tree_w(IN_W, NUM_IN);
  localparam int unsigned ACC_TW = ACC_W + 1;
  localparam logic        SX     = (SIGNED != 0);

  logic adv;

  // Whole pipeline moves together; a held result freezes everything upstream
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < int'(L); i++) begin : g_lvl
    localparam int unsigned W_IN    = level_w(IN_W, i);
    localparam int unsigned N_PAIRS = NUM_IN >> (i + 1);

    logic [2*N_PAIRS*W_IN-1:0]   ops;
    logic                        v_in;
    logic                        l_in;
    logic [N_PAIRS*(W_IN+1)-1:0] sums;
    logic                        v_out;
    logic                        l_out;

    if (i == 0) begin : g_first
      assign ops  = in_data;
      assign v_in = in_valid;
      assign l_in = in_last;
    end else begin : g_rest
      assign ops  = g_lvl[i-1].sums;
      assign v_in = g_lvl[i-1].v_out;
      assign l_in = g_lvl[i-1].l_out;
    end

    adder_tree_level #(
      .N_PAIRS(N_PAIRS),
      .W_IN   (W_IN),
      .SIGNED (SIGNED)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .in_valid (v_in),
      .in_last  (l_in),
      .in_ci    ((i == 0) ? in_ci : 1'b0),
      .in_ops   (ops),
      .out_sums (sums),
      .out_valid(v_out),
      .out_last (l_out)
    );
  end

  logic [TREE_W-1:0] tree_sum;
  logic              tree_v;
  logic              tree_l;
  logic [ACC_W-1:0]  acc;
  logic              sticky_ovf;
  logic [ACC_TW-1:0] acc_ext;
  logic [ACC_TW-1:0] tree_ext;
  logic [ACC_TW-1:0] t;
  sat_res_t          sat_r;
  logic [ACC_W-1:0]  sat_val;
  logic              unused_sat_hi;

  assign tree_sum = g_lvl[L-1].sums;
  assign tree_v   = g_lvl[L-1].v_out;
  assign tree_l   = g_lvl[L-1].l_out;

  // One guard bit above ACC_W keeps t exact so the clamp decision is unambiguous
  assign acc_ext  = {SX & acc[ACC_W-1], acc};
  assign tree_ext = {{(ACC_TW - TREE_W){SX & tree_sum[TREE_W-1]}}, tree_sum};
  assign t        = acc_ext + tree_ext;
  assign sat_r    = saturate(SAT_TW'(t), ACC_W, SX);
  assign sat_val  = sat_r.value[ACC_W-1:0];
  assign unused_sat_hi = ^sat_r.value[SAT_W-1:ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      sticky_ovf <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else if (adv) begin
      out_valid <= tree_v & tree_l;
      if (tree_v) begin
        if (tree_l) begin
          out_sum    <= sat_val;
          out_ovf    <= sticky_ovf | sat_r.clamp;
          acc        <= '0;
          sticky_ovf <= 1'b0;
        end else begin
          acc        <= sat_val;
          sticky_ovf <= sticky_ovf | sat_r.clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Scoreboard bench: directed packets push hand-computed results; a monitor pops on each output handshake.
module tb_pipelined_adder_tree_acc;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a [3];
  logic        in_ready_a [3];
  logic [63:0] in_data_a  [3];
  logic        in_ci_a    [3];
  logic        in_last_a  [3];
  logic        out_valid_a[3];
  logic        out_ready_a[3];
  logic        out_ovf_a  [3];
  logic [15:0] sum0;
  logic [15:0] sum1;
  logic [10:0] sum2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  bit bp_done;

  always #5 clk = ~clk;

  pipelined_adder_tree_acc #(.NUM_IN(8), .IN_W(8), .ACC_W(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_data(in_data_a[0]), .in_ci(in_ci_a[0]), .in_last(in_last_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_sum(sum0), .out_ovf(out_ovf_a[0]));

  pipelined_adder_tree_acc #(.NUM_IN(8), .IN_W(8), .ACC_W(16), .SIGNED(1)) u_sgn16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_data(in_data_a[1]), .in_ci(in_ci_a[1]), .in_last(in_last_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_sum(sum1), .out_ovf(out_ovf_a[1]));

  pipelined_adder_tree_acc #(.NUM_IN(8), .IN_W(8), .ACC_W(11), .SIGNED(1)) u_sgn11 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_data(in_data_a[2]), .in_ci(in_ci_a[2]), .in_last(in_last_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_sum(sum2), .out_ovf(out_ovf_a[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [15:0] sum, input logic ovf);
    exp_t e;
    e.sum = sum;
    e.ovf = ovf;
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Present one beat with every lane equal to lane; returns #1 after the accepting edge
  task automatic send(input int sel, input logic [7:0] lane, input logic ci, input logic last);
    bit ok;
    ok = 1'b0;
    in_data_a[sel]  = {8{lane}};
    in_ci_a[sel]    = ci;
    in_last_a[sel]  = last;
    in_valid_a[sel] = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready_a[sel];
      @(posedge clk);
      #1;
    end
    in_valid_a[sel] = 1'b0;
    in_last_a[sel]  = 1'b0;
    if (!ok) check($sformatf("send_timeout%0d", sel), 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 200 && !empty; n++) begin
      @(posedge clk);
      #1;
      empty = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
    end
    check("drain", 32'(empty), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected result
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && out_valid_a[i] && out_ready_a[i]) begin
        exp_t        e;
        logic [15:0] act;
        int          qs;
        case (i)
          0:       begin qs = q0.size(); act = sum0; end
          1:       begin qs = q1.size(); act = sum1; end
          default: begin qs = q2.size(); act = {5'd0, sum2}; end
        endcase
        if (qs == 0) begin
          check($sformatf("sb%0d_unexpected", i), 32'd1, 32'd0);
        end else begin
          case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check($sformatf("sb%0d_sum", i), 32'(act), 32'(e.sum));
          check($sformatf("sb%0d_ovf", i), 32'(out_ovf_a[i]), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      in_data_a[i]   = '0;
      in_ci_a[i]     = 1'b0;
      in_last_a[i]   = 1'b0;
      out_ready_a[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("rst_in_ready",  32'(in_ready_a[0]),  32'd1);
    check("rst_out_sum",   32'(sum0),           32'd0);
    check("rst_out_ovf",   32'(out_ovf_a[0]),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat, all 0xFF plus carry-in; result appears 4 cycles after accept
    push(0, 16'd2041, 1'b0);
    send(0, 8'hFF, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("lat_early", 32'(out_valid_a[0]), 32'd0);
    @(posedge clk);
    #1;
    check("lat_on", 32'(out_valid_a[0]), 32'd1);
    @(posedge clk);
    #1;
    check("lat_off", 32'(out_valid_a[0]), 32'd0);

    // Three-beat packet then a single beat proving the accumulator cleared
    push(0, 16'd24, 1'b0);
    send(0, 8'd1, 1'b0, 1'b0);
    send(0, 8'd1, 1'b0, 1'b0);
    send(0, 8'd1, 1'b0, 1'b1);
    push(0, 16'd16, 1'b0);
    send(0, 8'd2, 1'b0, 1'b1);

    // Unsigned saturation across 33 beats, then a clean zero packet
    push(0, 16'hFFFF, 1'b1);
    for (int b = 0; b < 33; b++) send(0, 8'hFF, 1'b0, b == 32);
    push(0, 16'd0, 1'b0);
    send(0, 8'd0, 1'b0, 1'b1);

    // Signed lanes: exact negative sum, and signed clamp at ACC_W = 11
    push(1, 16'hFC01, 1'b0);
    send(1, 8'h80, 1'b1, 1'b1);
    push(2, 16'h0400, 1'b1);
    send(2, 8'h80, 1'b0, 1'b0);
    send(2, 8'h80, 1'b0, 1'b1);
    drain();

    // Backpressure: six single-beat packets with the output blocked
    out_ready_a[0] = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          push(0, 16'(8 * (p + 1) + (p % 2)), 1'b0);
          send(0, 8'(p + 1), 1'(p % 2), 1'b1);
        end
        bp_done = 1'b1;
      end
    join_none
    repeat (12) @(posedge clk);
    #1;
    check("bp_in_ready", 32'(in_ready_a[0]),  32'd0);
    check("bp_hold_v",   32'(out_valid_a[0]), 32'd1);
    check("bp_hold_sum", 32'(sum0),           32'd8);
    out_ready_a[0] = 1'b1;
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (out_valid_a[0]) cnt++;
      @(posedge clk);
    end
    #1;
    check("bp_stream", 32'(cnt), 32'd6);
    for (int n = 0; n < 100 && !bp_done; n++) @(posedge clk);
    #1;
    check("bp_done", 32'(bp_done), 32'd1);
    drain();

    // Reset mid-packet drops the partial sum
    send(0, 8'd5, 1'b0, 1'b0);
    send(0, 8'd5, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready_a[0]),  32'd1);
    push(0, 16'd8, 1'b0);
    send(0, 8'd1, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
